// File: rtl/coreriscv_axi4_tl_pkg.sv
// TileLink acquire encodings and AXI4 constants shared by the acquire-to-AXI request path.
package coreriscv_axi4_tl_pkg;

  localparam logic [2:0] A_GET       = 3'd0;
  localparam logic [2:0] A_GET_BLOCK = 3'd1;
  localparam logic [2:0] A_PUT       = 3'd2;
  localparam logic [2:0] A_PUT_BLOCK = 3'd3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         TL_BEATS       = 8;

  // Field positions inside the 12-bit acquire union.
  localparam int U_BYTE_HI = 11;
  localparam int U_BYTE_LO = 9;
  localparam int U_SIZE_HI = 8;
  localparam int U_SIZE_LO = 6;
  localparam int U_MASK_HI = 8;
  localparam int U_MASK_LO = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } acq_state_e;

  // A PutBlock may only open a burst on beat 0; everything outside the builtin 0..3 set is dropped.
  function automatic logic acq_unsupported(input logic       builtin,
                                           input logic [2:0] a_type,
                                           input logic [2:0] addr_beat);
    return !builtin || a_type[2] || ((a_type == A_PUT_BLOCK) && (addr_beat != 3'd0));
  endfunction

endpackage

// File: rtl/coreriscv_axi4_req_slot.sv
// One-entry valid/ready output register; a full slot draining this cycle can reload at once.
module coreriscv_axi4_req_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         free
);

  assign free = !valid || ready;

  // Valid flag: set on load, cleared when the consumer takes the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

  // Payload register, intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end else begin
      dout <= dout;
    end
  end

endmodule

// File: rtl/coreriscv_axi4_acquire_axi_req.sv
// Converts arbitrated builtin TileLink acquires into registered AXI4 AR, AW and W traffic.
module coreriscv_axi4_acquire_axi_req
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int ID_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [25:0]         in_addr_block,
  input  logic [1:0]          in_client_xact_id,
  input  logic [2:0]          in_addr_beat,
  input  logic                in_is_builtin_type,
  input  logic [2:0]          in_a_type,
  input  logic [11:0]         in_union,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_chosen,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [ID_W-1:0]     aw_id,
  output logic [7:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [ID_W-1:0]     ar_id,
  output logic [7:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  output logic                err_unsupported
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int AX_W   = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int WB_W   = DATA_W + STRB_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [7:0]       BLOCK_LEN = 8'(BEATS - 1);

  acq_state_e       state_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic             err_r;

  logic             is_get_s, is_wr_s, unsup_s, burst_beat_s, fire_s;
  logic             ar_load_s, aw_load_s, w_load_s;
  logic             ar_free_s, aw_free_s, w_free_s;
  logic [ID_W-1:0]  id_s;
  logic [AX_W-1:0]  ar_din_s, aw_din_s, ar_dout_s, aw_dout_s;
  logic [WB_W-1:0]  w_din_s, w_dout_s;
  logic             unused_s;

  assign unused_s = in_union[0];
  assign id_s     = {in_chosen, in_client_xact_id};
  assign fire_s   = in_valid && in_ready;

  // Acquire decode and acceptance; in BURST only further PutBlock beats may enter.
  always_comb begin
    is_get_s     = in_is_builtin_type && ((in_a_type == A_GET) || (in_a_type == A_GET_BLOCK));
    is_wr_s      = in_is_builtin_type && ((in_a_type == A_PUT) ||
                   ((in_a_type == A_PUT_BLOCK) && (in_addr_beat == 3'd0)));
    unsup_s      = acq_unsupported(in_is_builtin_type, in_a_type, in_addr_beat);
    burst_beat_s = in_is_builtin_type && (in_a_type == A_PUT_BLOCK);
    in_ready     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (unsup_s) begin
          in_ready = 1'b1;
        end else if (is_get_s) begin
          in_ready = ar_free_s;
        end else if (is_wr_s) begin
          in_ready = aw_free_s && w_free_s;
        end else begin
          in_ready = 1'b0;
        end
      end
      ST_BURST: in_ready = burst_beat_s && w_free_s;
      default:  in_ready = 1'b0;
    endcase
    ar_load_s = fire_s && (state_r == ST_IDLE) && !unsup_s && is_get_s;
    aw_load_s = fire_s && (state_r == ST_IDLE) && !unsup_s && is_wr_s;
    w_load_s  = aw_load_s || (fire_s && (state_r == ST_BURST));
  end

  // Channel payloads built from the incoming acquire.
  always_comb begin
    if (in_a_type == A_GET_BLOCK) begin
      ar_din_s = {in_addr_block, 6'b000000, id_s, BLOCK_LEN, 3'd3, AXI_BURST_INCR};
    end else begin
      ar_din_s = {in_addr_block, in_addr_beat, in_union[U_BYTE_HI:U_BYTE_LO], id_s, 8'd0,
                  in_union[U_SIZE_HI:U_SIZE_LO], AXI_BURST_INCR};
    end
    if (in_a_type == A_PUT_BLOCK) begin
      aw_din_s = {in_addr_block, 6'b000000, id_s, BLOCK_LEN, 3'd3, AXI_BURST_INCR};
    end else begin
      aw_din_s = {in_addr_block, in_addr_beat, 3'b000, id_s, 8'd0, 3'd3, AXI_BURST_INCR};
    end
    if (state_r == ST_BURST) begin
      w_din_s = {in_data, {STRB_W{1'b1}}, (beat_cnt_r == LAST_BEAT)};
    end else if (in_a_type == A_PUT) begin
      w_din_s = {in_data, in_union[U_MASK_HI:U_MASK_LO], 1'b1};
    end else begin
      w_din_s = {in_data, {STRB_W{1'b1}}, 1'b0};
    end
  end

  // Burst sequencing and the unsupported/misaligned-beat error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fire_s && unsup_s) begin
            err_r <= 1'b1;
          end else if (aw_load_s && (in_a_type == A_PUT_BLOCK)) begin
            beat_cnt_r <= CNT_W'(1);
            state_r    <= ST_BURST;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (fire_s) begin
            // A misaligned beat is flagged but still counted; the sequence is not realigned.
            err_r      <= (in_addr_beat != beat_cnt_r);
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (beat_cnt_r == LAST_BEAT) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_BURST;
            end
          end else begin
            state_r <= ST_BURST;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign err_unsupported = err_r;

  coreriscv_axi4_req_slot #(.W(AX_W)) u_ar_slot (
    .clk(clk), .reset(reset), .load(ar_load_s), .din(ar_din_s), .ready(ar_ready),
    .valid(ar_valid), .dout(ar_dout_s), .free(ar_free_s)
  );

  coreriscv_axi4_req_slot #(.W(AX_W)) u_aw_slot (
    .clk(clk), .reset(reset), .load(aw_load_s), .din(aw_din_s), .ready(aw_ready),
    .valid(aw_valid), .dout(aw_dout_s), .free(aw_free_s)
  );

  coreriscv_axi4_req_slot #(.W(WB_W)) u_w_slot (
    .clk(clk), .reset(reset), .load(w_load_s), .din(w_din_s), .ready(w_ready),
    .valid(w_valid), .dout(w_dout_s), .free(w_free_s)
  );

  assign {ar_addr, ar_id, ar_len, ar_size, ar_burst} = ar_dout_s;
  assign {aw_addr, aw_id, aw_len, aw_size, aw_burst} = aw_dout_s;
  assign {w_data, w_strb, w_last}                    = w_dout_s;

endmodule

// File: doc/coreriscv_axi4_acquire_axi_req.md
Name: coreriscv_axi4_acquire_axi_req

Overview:
- Consumes the arbitrated TileLink Acquire stream (2-client locking round-robin arbiter output, plus its chosen index).
- Converts each builtin acquire into AXI4 request-channel traffic:
  - Get and GetBlock produce AR.
  - Put and PutBlock produce AW plus W beats.
- Sits between the acquire arbiter and the AXI4 master port. Each output channel is registered.

Parameters:
- ADDR_W, 32, AXI address width; equals 26 block bits + 3 beat bits + 3 byte bits.
- DATA_W, 64, data width; STRB_W = DATA_W/8.
- BEATS, 8, beats per block; the beat counter is log2(BEATS) bits.
- ID_W, 3, AXI ID width; ID = {in_chosen, client_xact_id}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid / in_ready  in/out  1  acquire handshake
- in_addr_block  in  26  block address
- in_client_xact_id  in  2  transaction id
- in_addr_beat  in  3  beat index
- in_is_builtin_type  in  1  builtin flag
- in_a_type  in  3  0=Get, 1=GetBlock, 2=Put, 3=PutBlock
- in_union  in  12  Get: [11:9] addr_byte, [8:6] size; Put: [8:1] wmask
- in_data  in  64  put data
- in_chosen  in  1  arbiter chosen client
- aw_valid / aw_ready  out/in  1  AW handshake
- aw_addr  out  32;  aw_id  out  3;  aw_len  out  8;  aw_size  out  3;  aw_burst  out  2
- w_valid / w_ready  out/in  1  W handshake
- w_data  out  64;  w_strb  out  8;  w_last  out  1
- ar_valid / ar_ready  out/in  1  AR handshake
- ar_addr  out  32;  ar_id  out  3;  ar_len  out  8;  ar_size  out  3;  ar_burst  out  2
- err_unsupported  out  1  one-cycle pulse when an unsupported acquire is dropped

Behaviour:
- Reset: clk and reset as decided (reset synchronous, active-high).
  - Cleared: aw_valid, w_valid, ar_valid, err_unsupported; state=IDLE; beat_cnt=0.
  - Payload registers are not reset.
- Each output channel is a one-entry register.
  - slot_free = !x_valid | x_ready, so a full slot that drains in the same cycle also accepts a new beat.
  - Acceptance into a slot occurs at cycle N; x_valid is high from N+1.
  - x_valid holds, with payload stable, until x_ready.
- in_ready, state IDLE:
  - Get/GetBlock: ar slot_free.
  - Put: aw and w slots both free.
  - PutBlock with addr_beat==0: aw and w slots both free.
  - Unsupported: 1. Unsupported = !is_builtin, or a_type in 4..7, or PutBlock with addr_beat!=0.
- in_ready, state BURST: w slot_free, and only for a PutBlock beat. Any other acquire is stalled (in_ready=0).
- Get: ar_addr={block,beat,addr_byte}, ar_len=0, ar_size=union[8:6], ar_burst=INCR(2'b01).
- GetBlock: ar_addr={block,6'b0}, ar_len=7, ar_size=3, ar_burst=INCR.
- Put: aw_addr={block,beat,3'b0}, aw_len=0, aw_size=3, INCR; w_data=data, w_strb=union[8:1], w_last=1.
- PutBlock beat 0:
  - AW: {block,6'b0}, len 7, size 3.
  - W: data, strb 8'hFF, last 0.
  - beat_cnt<=1; state<=BURST.
- BURST beats:
  - Each accepted beat loads W with strb FF and increments beat_cnt.
  - w_last=1 when beat_cnt==7; the beat_cnt 7→0 wrap returns the state to IDLE.
  - If in_addr_beat!=beat_cnt: the beat is still accepted and err_unsupported pulses; the sequence is not realigned.
- AW/W ordering: W beats may be issued before AW completes (AXI-legal). AW is never re-issued mid-burst.
- An unsupported acquire is consumed in one cycle: err_unsupported=1 at N+1 and no AXI output.
- ID for all channels = {in_chosen, in_client_xact_id}, captured at acceptance.
- Reset mid-burst aborts: state IDLE, all valids drop the next cycle, partial AXI burst is abandoned. The system resets the AXI slave together with this block.

Decomposition:
- Package coreriscv_axi4_tl_pkg:
  - acquire type codes (GET=0, GET_BLOCK=1, PUT=2, PUT_BLOCK=3);
  - AXI burst INCR, BEATS, union field bit positions.
- Sub-module coreriscv_axi4_req_slot: one-entry valid/ready register, parameterised width. Instantiated three times (AW, W, AR).

Test Plan:
- Get: block=0x0000123, beat=2, union[11:9]=4, size=2, xact=1, chosen=1 → next cycle ar_valid, ar_addr=0x000048D4, ar_id=3'b101, ar_len=0, ar_size=2.
- GetBlock with ar_ready held low 5 cycles → ar_valid stays high with payload stable; a second Get stalls (in_ready=0) until ar_ready; then the second Get is accepted in the same cycle AR drains.
- PutBlock 8 beats, data=beat index, all readies=1 → exactly one AW (len 7, addr {block,6'b0}); 8 W beats with strb FF; w_last only on the 8th; state returns to IDLE; back-to-back throughput of 1 beat/cycle.
- Put with union[8:1]=8'h0F, w_ready=0 for 3 cycles → W held stable; strb=0x0F, w_last=1; aw_valid independent of W stall.
- a_type=5 builtin, then is_builtin=0 → each accepted in 1 cycle; err_unsupported pulses; no AW/AR/W valid.
- Reset asserted after PutBlock beat 3 → next cycle all valids 0, in_ready reflects IDLE. A new Get then issues normally.
